// File: rtl/imm_decode_stage.sv
// RISC-V immediate generation: classify opcode, build XLEN-wide immediate + format code.
// Latency: 1 cycle (accept at edge N, result visible in cycle N+1).
// Backpressure: main + skid register; in_ready is registered and drops while the skid holds an entry.
module imm_decode_stage #(
    parameter int XLEN     = 32,
    parameter bit RV64_OPS = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt
);
    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_Z   = 3'd6;
    localparam logic [2:0] FMT_ILL = 3'd7;

    // The 32-bit word opcodes only exist on a 64-bit datapath.
    localparam bit EN_RV64 = RV64_OPS && (XLEN == 64);

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
    } entry_t;

    logic [2:0]  dec_fmt;
    logic [31:0] imm32;
    entry_t      dec;

    entry_t main_q, main_n;
    entry_t skid_q, skid_n;
    logic   main_vld, main_vld_n;
    logic   skid_vld, skid_vld_n;
    logic   in_ready_q;
    logic   accept;
    logic   drain;

    always_comb begin
        dec_fmt = FMT_ILL;
        case (in_instr[6:0])
            7'b0110111, 7'b0010111:                       dec_fmt = FMT_U;
            7'b1101111:                                   dec_fmt = FMT_J;
            7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111: dec_fmt = FMT_I;
            7'b1100011:                                   dec_fmt = FMT_B;
            7'b0100011:                                   dec_fmt = FMT_S;
            7'b0110011:                                   dec_fmt = FMT_R;
            7'b1110011:                                   dec_fmt = in_instr[14] ? FMT_Z : FMT_I;
            7'b0011011:                                   dec_fmt = EN_RV64 ? FMT_I : FMT_ILL;
            7'b0111011:                                   dec_fmt = EN_RV64 ? FMT_R : FMT_ILL;
            default:                                      dec_fmt = FMT_ILL;
        endcase
    end

    // Every format fits in 32 bits already sign-extended (Z has bit 31 clear),
    // so a single signed widening to XLEN covers both datapath widths.
    always_comb begin
        imm32 = '0;
        case (dec_fmt)
            FMT_I:   imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            FMT_S:   imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FMT_B:   imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
            FMT_U:   imm32 = {in_instr[31:12], 12'b0};
            FMT_J:   imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
            FMT_Z:   imm32 = {27'b0, in_instr[19:15]};
            default: imm32 = '0;
        endcase
    end

    always_comb begin
        dec.instr = in_instr;
        dec.imm   = XLEN'($signed(imm32));
        dec.fmt   = dec_fmt;
    end

    assign accept = in_valid && in_ready_q;
    assign drain  = main_vld && out_ready;

    // in_ready is low whenever the skid is full, so a skid->main move never
    // coincides with an accept.
    always_comb begin
        main_n     = main_q;
        skid_n     = skid_q;
        main_vld_n = main_vld;
        skid_vld_n = skid_vld;
        if (!main_vld || drain) begin
            if (skid_vld) begin
                main_n     = skid_q;
                main_vld_n = 1'b1;
                skid_vld_n = 1'b0;
            end else begin
                main_vld_n = accept;
                if (accept) begin
                    main_n = dec;
                end
            end
        end else if (accept) begin
            skid_n     = dec;
            skid_vld_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld   <= 1'b0;
            skid_vld   <= 1'b0;
            in_ready_q <= 1'b1;
        end else if (flush) begin
            main_vld   <= 1'b0;
            skid_vld   <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            main_q     <= main_n;
            skid_q     <= skid_n;
            main_vld   <= main_vld_n;
            skid_vld   <= skid_vld_n;
            in_ready_q <= !skid_vld_n;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_vld;
    assign out_instr = main_q.instr;
    assign out_imm   = main_q.imm;
    assign out_fmt   = main_q.fmt;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: a 32-bit and a 64-bit (RV64_OPS) instance share one
// input stream and are checked every cycle against a queue-based reference model.
module tb_imm_decode_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic        out_ready = 1'b0;

    logic        r32, v32, r64, v64;
    logic [31:0] oi32, oi64;
    logic [31:0] oimm32;
    logic [63:0] oimm64;
    logic [2:0]  of32, of64;

    int checks = 0;
    int failures = 0;

    logic [31:0] mq[$];
    logic [31:0] obs[$];
    logic        mrdy = 1'b1;
    int          n_acc = 0;

    logic [6:0] ops [13] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h0F,
                             7'h63, 7'h23, 7'h33, 7'h73, 7'h1B, 7'h3B};

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32), .RV64_OPS(1'b0)) dut32 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(r32), .in_instr(in_instr),
        .out_valid(v32), .out_ready(out_ready),
        .out_instr(oi32), .out_imm(oimm32), .out_fmt(of32)
    );

    imm_decode_stage #(.XLEN(64), .RV64_OPS(1'b1)) dut64 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(r64), .in_instr(in_instr),
        .out_valid(v64), .out_ready(out_ready),
        .out_instr(oi64), .out_imm(oimm64), .out_fmt(of64)
    );

    function automatic logic [2:0] ref_fmt(input logic [31:0] ins, input bit rv64);
        case (ins[6:0])
            7'h37, 7'h17:               return 3'd4;
            7'h6F:                      return 3'd5;
            7'h67, 7'h03, 7'h13, 7'h0F: return 3'd1;
            7'h63:                      return 3'd3;
            7'h23:                      return 3'd2;
            7'h33:                      return 3'd0;
            7'h73:                      return ins[14] ? 3'd6 : 3'd1;
            7'h1B:                      return rv64 ? 3'd1 : 3'd7;
            7'h3B:                      return rv64 ? 3'd0 : 3'd7;
            default:                    return 3'd7;
        endcase
    endfunction

    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] f);
        longint v;
        case (f)
            3'd1:    v = longint'($signed(ins[31:20]));
            3'd2:    v = longint'($signed({ins[31:25], ins[11:7]}));
            3'd3:    v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            3'd4:    v = longint'($signed({ins[31:12], 12'h000}));
            3'd5:    v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            3'd6:    v = longint'(ins[19:15]);
            default: v = 0;
        endcase
        return 64'(v);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int pick;
        r = $urandom();
        pick = $urandom_range(0, 15);
        if (pick < 13) r[6:0] = ops[pick];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs_v, input logic [63:0] exp_v);
        checks++;
        assert (obs_v === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs_v, exp_v);
        end
    endtask

    task automatic check_model();
        logic [2:0]  f32, f64;
        logic [63:0] e32, e64;
        chk("valid32", {63'b0, v32}, {63'b0, mq.size() > 0});
        chk("valid64", {63'b0, v64}, {63'b0, mq.size() > 0});
        chk("ready32", {63'b0, r32}, {63'b0, mrdy});
        chk("ready64", {63'b0, r64}, {63'b0, mrdy});
        if (mq.size() > 0) begin
            f32 = ref_fmt(mq[0], 1'b0);
            f64 = ref_fmt(mq[0], 1'b1);
            e32 = ref_imm(mq[0], f32);
            e64 = ref_imm(mq[0], f64);
            chk("instr32", {32'b0, oi32}, {32'b0, mq[0]});
            chk("instr64", {32'b0, oi64}, {32'b0, mq[0]});
            chk("fmt32", {61'b0, of32}, {61'b0, f32});
            chk("fmt64", {61'b0, of64}, {61'b0, f64});
            chk("imm32", {32'b0, oimm32}, {32'b0, e32[31:0]});
            chk("imm64", oimm64, e64);
        end
    endtask

    // Inputs are set after a falling edge; one rising edge is taken, the
    // reference queue advances, and outputs are checked on the next falling edge.
    task automatic step();
        logic pop, push;
        if (v32 && out_ready) obs.push_back(oi32);
        @(posedge clk);
        if (reset || flush) begin
            mq.delete();
            mrdy = 1'b1;
        end else begin
            pop  = (mq.size() > 0) && out_ready;
            push = in_valid && mrdy;
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back(in_instr);
                n_acc++;
            end
            mrdy = (mq.size() < 2);
        end
        @(negedge clk);
        check_model();
    endtask

    task automatic send(input logic [31:0] ins);
        in_valid = 1'b1;
        in_instr = ins;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] bp [4];
        logic        was_rdy;
        int          t;
        int          cyc;

        bp[0] = 32'h00100093; bp[1] = 32'h00200113;
        bp[2] = 32'h00300193; bp[3] = 32'h00400213;

        // Reset values
        reset = 1'b1;
        step(); step();
        chk("rst_valid", {63'b0, v32}, 64'd0);
        chk("rst_ready", {63'b0, r32}, 64'd1);
        chk("rst_instr", {32'b0, oi32}, 64'd0);
        chk("rst_imm32", {32'b0, oimm32}, 64'd0);
        chk("rst_imm64", oimm64, 64'd0);
        chk("rst_fmt", {61'b0, of64}, 64'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        step();

        // Directed decode vectors
        send(32'hFFF00093);
        chk("addi_fmt", {61'b0, of32}, 64'd1);
        chk("addi_imm32", {32'b0, oimm32}, 64'hFFFFFFFF);
        chk("addi_imm64", oimm64, 64'hFFFFFFFFFFFFFFFF);
        send(32'h123450B7);
        chk("lui_fmt", {61'b0, of32}, 64'd4);
        chk("lui_imm", {32'b0, oimm32}, 64'h12345000);
        send(32'hFE000FE3);
        chk("beq_fmt", {61'b0, of32}, 64'd3);
        chk("beq_imm", {32'b0, oimm32}, 64'hFFFFFFFE);
        send(32'h300FD073);
        chk("csrrwi_fmt", {61'b0, of32}, 64'd6);
        chk("csrrwi_imm", {32'b0, oimm32}, 64'h1F);
        send(32'h00000000);
        chk("zero_fmt", {61'b0, of32}, 64'd7);
        chk("zero_imm", {32'b0, oimm32}, 64'd0);
        send(32'h800000B7);
        chk("lui64_imm", oimm64, 64'hFFFFFFFF80000000);
        send(32'h0010009B);
        chk("addiw_fmt64", {61'b0, of64}, 64'd1);
        chk("addiw_imm64", oimm64, 64'd1);
        chk("addiw_fmt32", {61'b0, of32}, 64'd7);
        step();

        // Backpressure: two accepts fill both entries, then outputs hold
        obs.delete();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = bp[0]; step();
        in_instr = bp[1]; step();
        chk("bp_ready_low", {63'b0, r32}, 64'd0);
        in_instr = bp[2];
        repeat (3) begin
            step();
            chk("bp_stable_instr", {32'b0, oi32}, {32'b0, bp[0]});
            chk("bp_stable_imm", {32'b0, oimm32}, 64'd1);
            chk("bp_ready_hold", {63'b0, r32}, 64'd0);
        end
        out_ready = 1'b1;
        for (int k = 2; k < 4; k++) begin
            in_instr = bp[k];
            t = 0;
            was_rdy = 1'b0;
            while (t < 20 && !was_rdy) begin
                was_rdy = r32;
                step();
                t++;
            end
            chk("bp_accept_timeout", {63'b0, was_rdy}, 64'd1);
        end
        in_valid = 1'b0;
        repeat (6) step();
        chk("bp_count", 64'(obs.size()), 64'd4);
        for (int k = 0; k < 4; k++)
            chk("bp_order", {32'b0, (obs.size() > k) ? obs[k] : 32'hDEADBEEF}, {32'b0, bp[k]});

        // Flush with both entries full and a concurrent in_valid
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = 32'h00500293; step();
        in_instr = 32'h00600313; step();
        in_instr = 32'h00700393;
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", {63'b0, v32}, 64'd0);
        chk("flush_ready", {63'b0, r64}, 64'd1);
        obs.delete();
        out_ready = 1'b1;
        repeat (4) step();
        chk("flush_nothing_out", 64'(obs.size()), 64'd0);

        // Reset mid-stream
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = 32'h00800413; step();
        in_instr = 32'h00900493; step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        in_valid = 1'b0;
        chk("mrst_valid", {63'b0, v64}, 64'd0);
        chk("mrst_ready", {63'b0, r32}, 64'd1);
        chk("mrst_instr", {32'b0, oi32}, 64'd0);
        chk("mrst_imm", oimm64, 64'd0);
        chk("mrst_fmt", {61'b0, of32}, 64'd0);
        out_ready = 1'b1;
        send(32'h00A00513);
        chk("post_rst_valid", {63'b0, v32}, 64'd1);
        chk("post_rst_instr", {32'b0, oi32}, 64'h00A00513);

        // Random valid/ready/flush traffic
        n_acc = 0;
        cyc = 0;
        while (n_acc < 10000 && cyc < 60000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 255) == 0);
            step();
            cyc++;
        end
        flush = 1'b0;
        in_valid = 1'b0;
        chk("rand_accept_count", {63'b0, n_acc >= 10000}, 64'd1);
        out_ready = 1'b1;
        repeat (4) step();
        chk("final_empty", {63'b0, v32}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
